// File: rtl/storage_pkg.sv
// Shared storage-controller definitions: QSPI opcodes, engine state encoding and helpers.
package storage_pkg;

  localparam int unsigned QSPI_ADDR_W = 24;

  localparam logic [7:0] QSPI_OP_FAST_READ_QUAD_OUT = 8'h6B;
  localparam logic [7:0] QSPI_OP_FAST_READ_QUAD_IO  = 8'hEB;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCmd   = 3'd1,
    StAddr  = 3'd2,
    StMode  = 3'd3,
    StDummy = 3'd4,
    StData  = 3'd5,
    StDesel = 3'd6
  } qspi_state_t;

  // Flash returns the byte at the lowest address first; it belongs in the word's low byte.
  function automatic logic [31:0] qspi_byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/qspi_nibble_shifter.sv
// Command/address output shift register and read-data assembly register for the QSPI engine.
module qspi_nibble_shifter
  import storage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        shift1_i,
  input  logic        shift4_i,
  input  logic        sample_i,
  input  logic [3:0]  nibble_i,
  output logic [3:0]  sout_o,
  output logic [31:0] word_o
);

  logic [31:0] sreg_q, sreg_d;
  logic [31:0] din_q, din_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = load_data_i;
    end else if (shift4_i) begin
      sreg_d = {sreg_q[27:0], 4'h0};
    end else if (shift1_i) begin
      sreg_d = {sreg_q[30:0], 1'b0};
    end
  end

  always_comb begin
    din_d = din_q;
    if (load_i) begin
      din_d = '0;
    end else if (sample_i) begin
      din_d = {din_q[27:0], nibble_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
      din_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      din_q  <= din_d;
    end
  end

  assign sout_o = sreg_q[31:28];
  assign word_o = qspi_byte_swap(din_q);

endmodule

// File: rtl/qspi_read_engine.sv
// Single-word QSPI fast-read engine (SCK = clk/2, mode 0).
// Define QSPI_QUAD_IO_EN for 0xEB quad-address reads; default build issues 0x6B.
module qspi_read_engine
  import storage_pkg::*;
#(
  parameter int unsigned DUMMY_CYCLES   = 8,
  parameter int unsigned CS_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  input  logic [3:0]  qspi_io_i,
  output logic [3:0]  qspi_io_o,
  output logic [3:0]  qspi_io_t,
  output logic        qspi_ck_o,
  output logic        qspi_cs_o
);

`ifdef QSPI_QUAD_IO_EN
  localparam logic [7:0]  Opcode    = QSPI_OP_FAST_READ_QUAD_IO;
  localparam logic [7:0]  AddrLast  = 8'(QSPI_ADDR_W / 4 - 1);
  localparam logic [7:0]  DummySck  = 8'd4;
  localparam qspi_state_t AfterAddr = StMode;
`else
  localparam logic [7:0]  Opcode    = QSPI_OP_FAST_READ_QUAD_OUT;
  localparam logic [7:0]  AddrLast  = 8'(QSPI_ADDR_W - 1);
  localparam logic [7:0]  DummySck  = 8'(DUMMY_CYCLES);
  localparam qspi_state_t AfterAddr = (DummySck == 8'd0) ? StData : StDummy;
`endif
  localparam logic [7:0] CmdLast   = 8'd7;
  localparam logic [7:0] DummyLast = DummySck - 8'd1;
  localparam logic [7:0] DataSck   = 8'd8;
  localparam logic [7:0] DeselLast = 8'(CS_HIGH_CYCLES - 2);

  qspi_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic        load, shift1, shift4, sample;
  logic [3:0]  sout;
  logic [31:0] word;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:24];

  qspi_nibble_shifter u_shifter (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_i      (load),
    .load_data_i ({Opcode, req_addr[23:0]}),
    .shift1_i    (shift1),
    .shift4_i    (shift4),
    .sample_i    (sample),
    .nibble_i    (qspi_io_i),
    .sout_o      (sout),
    .word_o      (word)
  );

  // phase_q = 0 is the SCK low half, 1 the high half; shifts and samples land on the
  // clk edge that ends the high half.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    load        = 1'b0;
    shift1      = 1'b0;
    shift4      = 1'b0;
    sample      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          load    = 1'b1;
          state_d = StCmd;
          cnt_d   = '0;
          phase_d = 1'b0;
        end
      end
      StCmd: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          shift1 = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == CmdLast) begin
            state_d = StAddr;
            cnt_d   = '0;
          end
        end
      end
      StAddr: begin
        phase_d = ~phase_q;
        if (phase_q) begin
`ifdef QSPI_QUAD_IO_EN
          shift4 = 1'b1;
`else
          shift1 = 1'b1;
`endif
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == AddrLast) begin
            state_d = AfterAddr;
            cnt_d   = '0;
          end
        end
      end
`ifdef QSPI_QUAD_IO_EN
      StMode: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = StDummy;
            cnt_d   = '0;
          end
        end
      end
`endif
      StDummy: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DummyLast) begin
            state_d = StData;
            cnt_d   = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == DataSck) begin
          // Extra low cycle after the last sample: register the word, then deselect.
          rsp_valid_d = 1'b1;
          rsp_data_d  = word;
          state_d     = (CS_HIGH_CYCLES > 1) ? StDesel : StIdle;
          cnt_d       = '0;
        end else begin
          phase_d = ~phase_q;
          if (phase_q) begin
            sample = 1'b1;
            cnt_d  = cnt_q + 8'd1;
          end
        end
      end
      StDesel: begin
        if (cnt_q == DeselLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = ~req_ready;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    qspi_cs_o = 1'b1;
    qspi_io_o = 4'h0;
    qspi_io_t = 4'hF;
    unique case (state_q)
      StCmd, StDummy, StData: qspi_cs_o = 1'b0;
      StAddr:                 qspi_cs_o = 1'b0;
      StMode:                 qspi_cs_o = 1'b0;
      default:                qspi_cs_o = 1'b1;
    endcase
    qspi_ck_o = phase_q & ~qspi_cs_o;
    // io2/io3 held high so WP# and HOLD# stay inactive during single-line phases.
    if (state_q == StCmd) begin
      qspi_io_o = {2'b11, 1'b0, sout[3]};
      qspi_io_t = 4'b0010;
    end else if (state_q == StAddr) begin
`ifdef QSPI_QUAD_IO_EN
      qspi_io_o = sout;
      qspi_io_t = 4'h0;
`else
      qspi_io_o = {2'b11, 1'b0, sout[3]};
      qspi_io_t = 4'b0010;
`endif
    end else if (state_q == StMode) begin
      qspi_io_o = 4'h0;
      qspi_io_t = 4'h0;
    end
  end

endmodule

// File: tb/tb_qspi_read_engine.sv
// Bench for qspi_read_engine: behavioural SPI flash plus a word-level expectation model.
module tb_qspi_read_engine;

  localparam int unsigned CsHigh = 2;
`ifdef QSPI_QUAD_IO_EN
  localparam logic [7:0] ExpOp   = 8'hEB;
  localparam int         AddrSck = 6;
  localparam int         Pre     = 20;
  localparam int         Lat     = 57;
  localparam int         MidE    = 50;
`else
  localparam logic [7:0] ExpOp   = 8'h6B;
  localparam int         AddrSck = 24;
  localparam int         Pre     = 40;
  localparam int         Lat     = 97;
  localparam int         MidE    = 90;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
  logic [3:0]  qspi_io_i = 4'h0;
  logic [3:0]  qspi_io_o;
  logic [3:0]  qspi_io_t;
  logic        qspi_ck_o;
  logic        qspi_cs_o;

  qspi_read_engine #(
    .DUMMY_CYCLES   (8),
    .CS_HIGH_CYCLES (CsHigh)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .qspi_io_i (qspi_io_i),
    .qspi_io_o (qspi_io_o),
    .qspi_io_t (qspi_io_t),
    .qspi_ck_o (qspi_ck_o),
    .qspi_cs_o (qspi_cs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Flash contents: identity map in directed tests, seeded scramble in random tests.
  bit         plain = 1'b1;
  logic [7:0] seed  = 8'h00;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (plain) return a[7:0];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ seed;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_byte(a + 24'(i));
    return w;
  endfunction

  function automatic bit pins_ok(input int r, input logic [3:0] t, input logic [3:0] o);
    if (r < 8) return (t == 4'b0010) && (o[3:2] == 2'b11);
`ifdef QSPI_QUAD_IO_EN
    if (r < 8 + AddrSck) return t == 4'h0;
    if (r < 16) return (t == 4'h0) && (o == 4'h0);
`else
    if (r < 8 + AddrSck) return (t == 4'b0010) && (o[3:2] == 2'b11);
`endif
    return t == 4'hF;
  endfunction

  // Behavioural flash: captures on SCK rise, drives read data after SCK fall.
  int          rises = 0;
  logic [7:0]  cmd_cap = 8'h00;
  logic [23:0] addr_cap = 24'h0;
  bit          pin_bad = 1'b0;

  always @(qspi_ck_o or qspi_cs_o) begin
    if (qspi_cs_o) begin
      rises = 0;
    end else if (qspi_ck_o) begin
      if (rises == 0) pin_bad = 1'b0;
      if (!pins_ok(rises, qspi_io_t, qspi_io_o)) pin_bad = 1'b1;
      if (rises < 8) cmd_cap = {cmd_cap[6:0], qspi_io_o[0]};
`ifdef QSPI_QUAD_IO_EN
      else if (rises < 8 + AddrSck) addr_cap = {addr_cap[19:0], qspi_io_o};
`else
      else if (rises < 8 + AddrSck) addr_cap = {addr_cap[22:0], qspi_io_o[0]};
`endif
      rises++;
    end else if (rises >= Pre && rises < Pre + 8) begin
      logic [7:0] b;
      b = mem_byte(addr_cap + 24'((rises - Pre) / 2));
      qspi_io_i = ((rises - Pre) % 2 == 0) ? b[7:4] : b[3:0];
    end
  end

  int cyc = 0, acc_cnt = 0, acc_cyc = 0, acc_cyc_prev = 0, rsp_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (rst && req_valid && req_ready) begin
      acc_cnt++;
      acc_cyc_prev = acc_cyc;
      acc_cyc = cyc;
    end
    if (rst && rsp_valid) rsp_cnt++;
  end

  task automatic wait_ready();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    check_eq("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_rsp(output logic [31:0] d);
    d = '0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        d = rsp_data;
        break;
      end
    end
    check_eq("rsp_seen", 32'(rsp_valid), 32'd1);
  endtask

  task automatic read_check(input logic [31:0] a);
    logic [31:0] exp;
    int          lat;
    exp = exp_word(a[23:0]);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    check_eq("cs_fall_e0", 32'(qspi_cs_o), 32'd0);
    check_eq("ck_low_e0", 32'(qspi_ck_o), 32'd0);
    check_eq("io_t_cmd", 32'(qspi_io_t), 32'h2);
    check_eq("io0_op7", 32'(qspi_io_o[0]), 32'(ExpOp[7]));
    @(posedge clk); #1;
    check_eq("ck_rise_e1", 32'(qspi_ck_o), 32'd1);
    lat = 0;
    for (int k = 2; k <= 400; k++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check_eq("latency", 32'(lat), 32'(Lat));
    check_eq("rsp_data", rsp_data, exp);
    check_eq("flash_cmd", 32'(cmd_cap), 32'(ExpOp));
    check_eq("flash_addr", 32'(addr_cap), 32'(a[23:0]));
    check_eq("pin_setup", 32'(pin_bad), 32'd0);
    check_eq("cs_rise", 32'(qspi_cs_o), 32'd1);
    @(posedge clk); #1;
    check_eq("rsp_pulse", 32'(rsp_valid), 32'd0);
    check_eq("rsp_hold", rsp_data, exp);
    check_eq("cs_hold", 32'(qspi_cs_o), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int          a0, r0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", rsp_data, 32'd0);
    check_eq("rst_cs", 32'(qspi_cs_o), 32'd1);
    check_eq("rst_ck", 32'(qspi_ck_o), 32'd0);
    check_eq("rst_io_t", 32'(qspi_io_t), 32'hF);
    check_eq("rst_io_o", 32'(qspi_io_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    read_check(32'h0000_0005);
    read_check(32'hAB00_0002);
    read_check(32'h00FF_FFFE);
    read_check(32'h0000_0040);

    // Held request: one accept per idle period, second accept after the full period.
    wait_ready();
    a0 = acc_cnt;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    @(posedge clk); #1;
    req_addr = 32'h20;
    wait_rsp(d);
    check_eq("busy_rsp0", d, 32'h1312_1110);
    check_eq("busy_ready_low", 32'(req_ready), 32'd0);
    check_eq("busy_flag", 32'(busy), 32'd1);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (acc_cnt == a0 + 2) break;
    end
    req_valid = 1'b0;
    check_eq("busy_accepts", 32'(acc_cnt - a0), 32'd2);
    check_eq("b2b_period", 32'(acc_cyc - acc_cyc_prev), 32'(Lat + CsHigh));
    wait_rsp(d);
    check_eq("busy_rsp1", d, 32'h2322_2120);
    repeat (5) @(posedge clk);
    #1;
    check_eq("busy_no_extra", 32'(acc_cnt - a0), 32'd2);

    // Reset in the middle of the data phase.
    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h33;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (MidE - 1) @(posedge clk);
    @(posedge clk); #1;
    check_eq("mid_cs_low", 32'(qspi_cs_o), 32'd0);
    r0 = rsp_cnt;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_cs", 32'(qspi_cs_o), 32'd1);
    check_eq("mid_rst_ck", 32'(qspi_ck_o), 32'd0);
    check_eq("mid_rst_io_t", 32'(qspi_io_t), 32'hF);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    check_eq("mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);
    check_eq("mid_rsp_data", rsp_data, 32'd0);
    read_check(32'h0000_0077);

    plain = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seed = 8'($urandom);
      read_check($urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
